// File: rtl/loop_pattern_checker.sv
// Compares words looped back through transceiver B against the P-bank's expected patterns
// and accumulates word, word-error and bit-error statistics for the status bank.
module loop_pattern_checker #(
   parameter int unsigned DATA_WIDTH = 56,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_clr,
   input  logic [ADDR_WIDTH-1:0] i_pattern_num,
   input  logic                  i_data_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_data_rd,
   output logic [ADDR_WIDTH-1:0] o_exp_addr,
   input  logic [DATA_WIDTH-1:0] i_exp_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout,
   output logic [CNT_WIDTH-1:0]  o_word_cnt,
   output logic [CNT_WIDTH-1:0]  o_err_cnt,
   output logic [CNT_WIDTH-1:0]  o_bit_err_cnt,
   output logic                  o_first_err_valid,
   output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] last_q, addr_q, first_addr_q;
   logic [TW-1:0]         tmo_q;
   logic [DATA_WIDTH-1:0] diff_q;
   logic                  data_rd_q, done_q, timeout_q, first_valid_q;
   logic [CNT_WIDTH-1:0]  word_cnt_q, err_cnt_q, bit_err_q;
   logic [CNT_WIDTH-1:0]  word_cnt_d, err_cnt_d, bit_err_d;
   logic [CNT_WIDTH:0]    pop_cnt, bit_sum;
   logic                  diff_nz;

   // Saturating next values for the CHECK update; bit sum carries one extra bit for the clamp.
   always_comb begin
      pop_cnt = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         pop_cnt = pop_cnt + (CNT_WIDTH + 1)'(diff_q[i]);
      end
      bit_sum    = {1'b0, bit_err_q} + pop_cnt;
      bit_err_d  = bit_sum[CNT_WIDTH] ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
      word_cnt_d = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + CNT_WIDTH'(1);
      err_cnt_d  = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);
      diff_nz    = |diff_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_IDLE;
         last_q        <= '0;
         addr_q        <= '0;
         tmo_q         <= '0;
         diff_q        <= '0;
         data_rd_q     <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         word_cnt_q    <= '0;
         err_cnt_q     <= '0;
         bit_err_q     <= '0;
         first_valid_q <= 1'b0;
         first_addr_q  <= '0;
      end else begin
         data_rd_q <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  last_q        <= i_pattern_num;
                  addr_q        <= '0;
                  word_cnt_q    <= '0;
                  err_cnt_q     <= '0;
                  bit_err_q     <= '0;
                  first_valid_q <= 1'b0;
                  first_addr_q  <= '0;
                  state_q       <= S_FETCH;
               end
            end
            S_FETCH: begin
               tmo_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (i_data_valid) begin
                  diff_q    <= i_data ^ i_exp_data;
                  data_rd_q <= 1'b1;
                  state_q   <= S_CHECK;
               end else if (tmo_q == TMO_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_CHECK: begin
               word_cnt_q <= word_cnt_d;
               if (diff_nz) begin
                  err_cnt_q <= err_cnt_d;
                  bit_err_q <= bit_err_d;
                  if (!first_valid_q) begin
                     first_valid_q <= 1'b1;
                     first_addr_q  <= addr_q;
                  end
               end
               if (addr_q == last_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  addr_q  <= addr_q + ADDR_WIDTH'(1);
                  state_q <= S_FETCH;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         // Placed after the case so a clear overrides a coincident CHECK update.
         if (i_clr) begin
            word_cnt_q    <= '0;
            err_cnt_q     <= '0;
            bit_err_q     <= '0;
            first_valid_q <= 1'b0;
            first_addr_q  <= '0;
         end
      end
   end

   assign o_busy            = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign o_exp_addr        = addr_q;
   assign o_data_rd         = data_rd_q;
   assign o_done            = done_q;
   assign o_timeout         = timeout_q;
   assign o_word_cnt        = word_cnt_q;
   assign o_err_cnt         = err_cnt_q;
   assign o_bit_err_cnt     = bit_err_q;
   assign o_first_err_valid = first_valid_q;
   assign o_first_err_addr  = first_addr_q;

endmodule
